multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/write-back sequencing
// with a memory-wait timeout that parks the machine in a terminal FAULT state.
module multicycle_control_unit #(
   parameter int OPCODE_W    = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   input  logic                stall,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic                ir_write,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src,
   output logic                ext_sel,
   output logic [1:0]          alu_op,
   output logic                mem_read,
   output logic                mem_write,
   output logic                mem_to_reg,
   output logic                fault,
   output logic [2:0]          state
);

   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd7
   } state_t;

   localparam logic [2:0] OP_ADD    = 3'b000;
   localparam logic [2:0] OP_ADDI   = 3'b001;
   localparam logic [2:0] OP_SHIFT  = 3'b010;
   localparam logic [2:0] OP_ROTATE = 3'b011;
   localparam logic [2:0] OP_BEQ    = 3'b100;
   localparam logic [2:0] OP_SW     = 3'b101;
   localparam logic [2:0] OP_LW     = 3'b110;
   localparam logic [2:0] OP_JMP    = 3'b111;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op;
   logic             illegal;
   logic             timeout_hit;

   assign op          = opcode[2:0];
   assign illegal     = (opcode >> 3) != '0;
   assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT)) && !mem_ready;
   assign state       = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      ext_sel    = 1'b0;
      alu_op     = 2'b00;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      fault      = 1'b0;

      case (state_q)
         S_FETCH: begin
            if (!stall) begin
               mem_read = 1'b1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_d  = S_DECODE;
               end else if (timeout_hit) begin
                  state_d = S_FAULT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_DECODE: begin
            if (illegal) begin
               state_d = S_FAULT;
            end else if (op == OP_JMP) begin
               pc_write = 1'b1;
               pc_src   = 2'b10;
               state_d  = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (op)
               OP_ADD: begin
                  state_d = S_WB;
               end
               OP_ADDI: begin
                  alu_src = 1'b1;
                  ext_sel = 1'b1;
                  state_d = S_WB;
               end
               OP_SHIFT: begin
                  alu_src = 1'b1;
                  alu_op  = 2'b01;
                  state_d = S_WB;
               end
               OP_ROTATE: begin
                  alu_src = 1'b1;
                  alu_op  = 2'b10;
                  state_d = S_WB;
               end
               OP_BEQ: begin
                  alu_op   = 2'b11;
                  pc_src   = 2'b01;
                  pc_write = zero;
                  state_d  = S_FETCH;
               end
               OP_SW, OP_LW: begin
                  alu_src = 1'b1;
                  state_d = S_MEM;
               end
               OP_JMP: begin
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEM: begin
            mem_write = (op == OP_SW);
            mem_read  = (op == OP_LW);
            if (mem_ready) begin
               state_d = (op == OP_LW) ? S_WB : S_FETCH;
            end else if (timeout_hit) begin
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            if (op == OP_LW) begin
               mem_to_reg = 1'b1;
            end else begin
               reg_dst = 1'b1;
            end
            state_d = S_FETCH;
         end
         S_FAULT: begin
            fault = 1'b1;
         end
         default: begin
            state_d = S_FAULT;
         end
      endcase

      // Every wait phase starts its timeout window fresh.
      if (state_d != state_q) begin
         cnt_d = '0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: a route-table instruction model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_multicycle_control_unit;

   localparam int OPW = 4;
   localparam int TO  = 4;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src;
      logic       ext_sel;
      logic [1:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       fault;
      logic [2:0] state;
   } ctrl_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [OPW-1:0] opcode;
   logic           zero, mem_ready, stall;
   logic           pc_write, ir_write, reg_dst, reg_write, alu_src, ext_sel;
   logic           mem_read, mem_write, mem_to_reg, fault;
   logic [1:0]     pc_src, alu_op;
   logic [2:0]     state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.OPCODE_W(OPW), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .stall(stall), .pc_write(pc_write),
      .pc_src(pc_src), .ir_write(ir_write), .reg_dst(reg_dst),
      .reg_write(reg_write), .alu_src(alu_src), .ext_sel(ext_sel),
      .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .fault(fault), .state(state)
   );

   // Each instruction class walks a fixed route of phases; -1 ends the route.
   int routes [8][5] = '{
      '{0, 1, 2, 4, -1}, '{0, 1, 2, 4, -1}, '{0, 1, 2, 4, -1}, '{0, 1, 2, 4, -1},
      '{0, 1, 2, -1, -1}, '{0, 1, 2, 3, -1}, '{0, 1, 2, 3, 4}, '{0, 1, -1, -1, -1}
   };
   int exec_alu_src [8] = '{0, 1, 1, 1, 0, 1, 1, 0};
   int exec_ext     [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
   int exec_alu_op  [8] = '{0, 0, 1, 2, 3, 0, 0, 0};

   int    m_pos, m_wait, m_o, m_st;
   bit    m_fault;
   ctrl_t exp_c, act_c;

   assign m_o   = int'(opcode[2:0]);
   assign m_st  = m_fault ? 7 : routes[m_o][m_pos];
   assign act_c = {pc_write, pc_src, ir_write, reg_dst, reg_write, alu_src, ext_sel,
                   alu_op, mem_read, mem_write, mem_to_reg, fault, state};

   function automatic int next_pos(input int o, input int pos);
      if (pos < 4 && routes[o][pos+1] != -1) return pos + 1;
      return 0;
   endfunction

   function automatic ctrl_t model_outputs(input int st, input logic [OPW-1:0] op,
                                           input logic z, input logic rdy, input logic stl);
      ctrl_t c;
      int    o;
      c = '0;
      o = int'(op[2:0]);
      c.state = 3'(st);
      case (st)
         0: if (!stl) begin
               c.mem_read = 1'b1;
               if (rdy) begin
                  c.ir_write = 1'b1;
                  c.pc_write = 1'b1;
               end
            end
         1: if (int'(op) < 8 && o == 7) begin
               c.pc_write = 1'b1;
               c.pc_src   = 2'b10;
            end
         2: begin
               c.alu_src = (exec_alu_src[o] != 0);
               c.ext_sel = (exec_ext[o] != 0);
               c.alu_op  = 2'(exec_alu_op[o]);
               if (o == 4) begin
                  c.pc_src   = 2'b01;
                  c.pc_write = z;
               end
            end
         3: begin
               c.mem_write = (o == 5);
               c.mem_read  = (o == 6);
            end
         4: begin
               c.reg_write = 1'b1;
               if (o == 6) c.mem_to_reg = 1'b1;
               else        c.reg_dst    = 1'b1;
            end
         7: c.fault = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   // Model advance: memory phases wait on mem_ready with a bounded budget.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pos   <= 0;
         m_wait  <= 0;
         m_fault <= 1'b0;
      end else if (!m_fault) begin
         if (m_st == 0 || m_st == 3) begin
            if (!(m_st == 0 && stall)) begin
               if (mem_ready) begin
                  m_pos  <= next_pos(m_o, m_pos);
                  m_wait <= 0;
               end else if (TO != 0 && m_wait == TO) begin
                  m_fault <= 1'b1;
               end else begin
                  m_wait <= m_wait + 1;
               end
            end
         end else if (m_st == 1 && int'(opcode) >= 8) begin
            m_fault <= 1'b1;
         end else begin
            m_pos  <= next_pos(m_o, m_pos);
            m_wait <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         exp_c = model_outputs(m_st, opcode, zero, mem_ready, stall);
         checks++;
         if (act_c !== exp_c) begin
            errors++;
            $display("[TB] FAIL cycle_compare t=%0t actual=%h expected=%h", $time, act_c, exp_c);
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [OPW-1:0] op, input logic z,
                                input logic rdy, input logic stl);
      @(posedge clk);
      #1;
      opcode    = op;
      zero      = z;
      mem_ready = rdy;
      stall     = stl;
      @(negedge clk);
   endtask

   task automatic doReset();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("reset_state", int'(state), 0);
      checkOutput("reset_fault", int'(fault), 0);
      checkOutput("reset_mem_write", int'(mem_write), 0);
      stall     = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      int lw_rdy [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
      int lw_st  [8] = '{0, 1, 2, 3, 3, 3, 3, 4};
      int alu_ops [3] = '{0, 2, 3};
      int alu_exp [3] = '{0, 1, 2};
      int read_cnt;

      opcode = '0; zero = 1'b0; mem_ready = 1'b0; stall = 1'b1; rst_n = 1'b0;
      #2;
      checkOutput("reset_state", int'(state), 0);
      checkOutput("reset_fault", int'(fault), 0);
      checkOutput("reset_mem_read", int'(mem_read), 0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;

      // ADDI walk: 0,1,2,4 then back to FETCH
      applyStimulus(4'd1, 0, 1, 0);
      checkOutput("addi_fetch_state", int'(state), 0);
      checkOutput("addi_fetch_ir_write", int'(ir_write), 1);
      applyStimulus(4'd1, 0, 1, 0);
      checkOutput("addi_decode_state", int'(state), 1);
      applyStimulus(4'd1, 0, 1, 0);
      checkOutput("addi_exec_state", int'(state), 2);
      checkOutput("addi_exec_alu_src", int'(alu_src), 1);
      checkOutput("addi_exec_ext_sel", int'(ext_sel), 1);
      applyStimulus(4'd1, 0, 1, 0);
      checkOutput("addi_wb_state", int'(state), 4);
      checkOutput("addi_wb_reg_write", int'(reg_write), 1);
      checkOutput("addi_wb_reg_dst", int'(reg_dst), 1);
      applyStimulus(4'd1, 0, 0, 1);
      checkOutput("addi_done_state", int'(state), 0);

      // LW with three wait cycles in MEM: eight cycles in total
      read_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(4'd6, 0, lw_rdy[i][0], 0);
         checkOutput("lw_state_seq", int'(state), lw_st[i]);
         if (state == 3'd3 && mem_read) read_cnt++;
         if (i == 7) begin
            checkOutput("lw_wb_mem_to_reg", int'(mem_to_reg), 1);
            checkOutput("lw_wb_reg_dst", int'(reg_dst), 0);
         end
      end
      checkOutput("lw_mem_read_cycles", read_cnt, 4);
      applyStimulus(4'd6, 0, 0, 1);
      checkOutput("lw_done_state", int'(state), 0);

      // BEQ taken then not taken
      for (int z = 1; z >= 0; z--) begin
         applyStimulus(4'd4, z[0], 1, 0);
         applyStimulus(4'd4, z[0], 1, 0);
         applyStimulus(4'd4, z[0], 1, 0);
         checkOutput("beq_exec_state", int'(state), 2);
         checkOutput("beq_exec_pc_write", int'(pc_write), z);
         checkOutput("beq_exec_pc_src", int'(pc_src), 1);
         checkOutput("beq_exec_alu_op", int'(alu_op), 3);
         applyStimulus(4'd4, z[0], 0, 1);
         checkOutput("beq_done_state", int'(state), 0);
      end

      // JMP with the 4-bit opcode 0111
      applyStimulus(4'd7, 0, 1, 0);
      applyStimulus(4'd7, 0, 1, 0);
      checkOutput("jmp_decode_state", int'(state), 1);
      checkOutput("jmp_decode_pc_write", int'(pc_write), 1);
      checkOutput("jmp_decode_pc_src", int'(pc_src), 2);
      applyStimulus(4'd7, 0, 0, 1);
      checkOutput("jmp_done_state", int'(state), 0);

      // ADD / SHIFT / ROTATE ALU op selection
      for (int k = 0; k < 3; k++) begin
         applyStimulus(4'(alu_ops[k]), 0, 1, 0);
         applyStimulus(4'(alu_ops[k]), 0, 1, 0);
         applyStimulus(4'(alu_ops[k]), 0, 1, 0);
         checkOutput("alu_exec_alu_op", int'(alu_op), alu_exp[k]);
         applyStimulus(4'(alu_ops[k]), 0, 1, 0);
         checkOutput("alu_wb_state", int'(state), 4);
         applyStimulus(4'(alu_ops[k]), 0, 0, 1);
      end

      // SW with one wait cycle
      for (int i = 0; i < 3; i++) applyStimulus(4'd5, 0, 1, 0);
      applyStimulus(4'd5, 0, 0, 0);
      checkOutput("sw_mem_state", int'(state), 3);
      checkOutput("sw_mem_write", int'(mem_write), 1);
      applyStimulus(4'd5, 0, 1, 0);
      applyStimulus(4'd5, 0, 0, 1);
      checkOutput("sw_done_state", int'(state), 0);

      // Long stall in FETCH never times out
      for (int i = 0; i < 6; i++) begin
         applyStimulus(4'd0, 0, 0, 1);
         checkOutput("stall_mem_read", int'(mem_read), 0);
         checkOutput("stall_fault", int'(fault), 0);
      end
      for (int i = 0; i < 4; i++) applyStimulus(4'd0, 0, 1, 0);
      checkOutput("post_stall_wb_state", int'(state), 4);
      applyStimulus(4'd0, 0, 0, 1);

      // Reset in the middle of a SW memory access
      for (int i = 0; i < 3; i++) applyStimulus(4'd5, 0, 1, 0);
      applyStimulus(4'd5, 0, 0, 0);
      checkOutput("sw_abort_pre_write", int'(mem_write), 1);
      doReset();

      // SW stuck in MEM times out
      for (int i = 0; i < 3; i++) applyStimulus(4'd5, 0, 1, 0);
      for (int i = 0; i < 5; i++) applyStimulus(4'd5, 0, 0, 0);
      checkOutput("mem_timeout_last_wait", int'(state), 3);
      applyStimulus(4'd5, 0, 0, 0);
      checkOutput("mem_timeout_state", int'(state), 7);
      doReset();

      // FETCH timeout: fault on the fifth edge, sticky until reset
      for (int i = 0; i < 5; i++) applyStimulus(4'd0, 0, 0, 0);
      checkOutput("fetch_timeout_pre", int'(state), 0);
      applyStimulus(4'd0, 0, 0, 0);
      checkOutput("fetch_timeout_state", int'(state), 7);
      checkOutput("fetch_timeout_fault", int'(fault), 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'd7, 1, 1, 0);
         checkOutput("fault_sticky", int'(fault), 1);
         checkOutput("fault_no_pc_write", int'(pc_write), 0);
      end
      doReset();

      // Illegal 4-bit opcode 1000
      applyStimulus(4'd8, 0, 1, 0);
      applyStimulus(4'd8, 0, 1, 0);
      checkOutput("illegal_decode_state", int'(state), 1);
      applyStimulus(4'd8, 0, 1, 0);
      checkOutput("illegal_fault_state", int'(state), 7);
      checkOutput("illegal_fault", int'(fault), 1);
      doReset();
      applyStimulus(4'd0, 0, 0, 1);
      checkOutput("final_state", int'(state), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "[TB] watchdog");
   end

endmodule
